// File: rtl/vx_cta_dispatch.sv
// rtl/vx_cta_dispatch.sv - CTA intake, warp spawn and retire tracking; VX_CTA_DISPATCH_PERF_EN adds perf counters
module vx_cta_dispatch #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   task_valid,
    input  logic [XLEN-1:0]        task_start_pc,
    input  logic [XLEN-1:0]        task_param,
    input  logic [XLEN-1:0]        task_cta_x,
    input  logic [XLEN-1:0]        task_cta_y,
    input  logic [XLEN-1:0]        task_cta_z,
    input  logic [31:0]            task_cta_id,
    input  logic [31:0]            task_num_warps,
    output logic                   core_ready,
    output logic                   spawn_valid,
    input  logic                   spawn_ready,
    output logic [WW-1:0]          spawn_wid,
    output logic [XLEN-1:0]        spawn_pc,
    output logic [NUM_THREADS-1:0] spawn_tmask,
    input  logic                   warp_done_valid,
    input  logic [WW-1:0]          warp_done_wid,
    output logic [31:0]            cur_cta_id,
    output logic [XLEN-1:0]        cur_cta_x,
    output logic [XLEN-1:0]        cur_cta_y,
    output logic [XLEN-1:0]        cur_cta_z,
    output logic [XLEN-1:0]        cur_param,
    output logic                   cta_done,
    output logic                   grid_done,
    output logic                   cfg_err
`ifdef VX_CTA_DISPATCH_PERF_EN
    ,
    output logic [31:0]            perf_ctas,
    output logic [63:0]            perf_busy_cycles
`endif
);

    localparam int CW = $clog2(NUM_WARPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         spawn_cnt_q, spawn_cnt_d;
    logic [CW-1:0]         nwarps_q, nwarps_d;
    logic [NUM_WARPS-1:0]  live_q, live_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       param_q, param_d;
    logic [XLEN-1:0]       cta_x_q, cta_x_d;
    logic [XLEN-1:0]       cta_y_q, cta_y_d;
    logic [XLEN-1:0]       cta_z_q, cta_z_d;
    logic [31:0]           cta_id_q, cta_id_d;
    logic                  core_ready_q, core_ready_d;
    logic                  spawn_valid_q, spawn_valid_d;
    logic                  cta_done_q, cta_done_d;
    logic                  grid_done_q, grid_done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  accept;
    logic                  fire;

    // core_ready_q is only ever high in IDLE, so it alone qualifies an accept
    assign accept = task_valid && core_ready_q;
    assign fire   = spawn_valid_q && spawn_ready;

    always_comb begin
        state_d     = state_q;
        spawn_cnt_d = spawn_cnt_q;
        nwarps_d    = nwarps_q;
        live_d      = live_q;
        pc_d        = pc_q;
        param_d     = param_q;
        cta_x_d     = cta_x_q;
        cta_y_d     = cta_y_q;
        cta_z_d     = cta_z_q;
        cta_id_d    = cta_id_q;
        grid_done_d = grid_done_q;
        cfg_err_d   = cfg_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (task_cta_x == '1) begin
                        grid_done_d = 1'b1;
                    end else begin
                        pc_d        = task_start_pc;
                        param_d     = task_param;
                        cta_x_d     = task_cta_x;
                        cta_y_d     = task_cta_y;
                        cta_z_d     = task_cta_z;
                        cta_id_d    = task_cta_id;
                        spawn_cnt_d = '0;
                        live_d      = '0;
                        if (task_num_warps == 32'd0) begin
                            nwarps_d = CW'(1);
                        end else if (task_num_warps > 32'(NUM_WARPS)) begin
                            nwarps_d  = CW'(NUM_WARPS);
                            cfg_err_d = 1'b1;
                        end else begin
                            nwarps_d = task_num_warps[CW-1:0];
                        end
                        state_d = S_SPAWN;
                    end
                end
            end
            S_SPAWN: begin
                if (fire) begin
                    spawn_cnt_d = spawn_cnt_q + CW'(1);
                    if (spawn_cnt_q + CW'(1) == nwarps_q) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (live_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Retire is applied before spawn so a same-wid collision leaves the warp live
        if (state_q == S_SPAWN || state_q == S_RUN) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (warp_done_valid && warp_done_wid == WW'(i)) begin
                    live_d[i] = 1'b0;
                end
                if (fire && spawn_cnt_q[WW-1:0] == WW'(i)) begin
                    live_d[i] = 1'b1;
                end
            end
        end

        core_ready_d  = (state_d == S_IDLE) && !grid_done_d;
        spawn_valid_d = (state_d == S_SPAWN);
        cta_done_d    = (state_d == S_DONE);
    end

`ifdef VX_CTA_DISPATCH_PERF_EN
    logic [31:0] perf_ctas_q;
    logic [63:0] perf_busy_q;
    assign perf_ctas        = perf_ctas_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            spawn_cnt_q   <= '0;
            nwarps_q      <= '0;
            live_q        <= '0;
            pc_q          <= '0;
            param_q       <= '0;
            cta_x_q       <= '0;
            cta_y_q       <= '0;
            cta_z_q       <= '0;
            cta_id_q      <= '0;
            core_ready_q  <= 1'b1;
            spawn_valid_q <= 1'b0;
            cta_done_q    <= 1'b0;
            grid_done_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
`ifdef VX_CTA_DISPATCH_PERF_EN
            perf_ctas_q   <= '0;
            perf_busy_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            spawn_cnt_q   <= spawn_cnt_d;
            nwarps_q      <= nwarps_d;
            live_q        <= live_d;
            pc_q          <= pc_d;
            param_q       <= param_d;
            cta_x_q       <= cta_x_d;
            cta_y_q       <= cta_y_d;
            cta_z_q       <= cta_z_d;
            cta_id_q      <= cta_id_d;
            core_ready_q  <= core_ready_d;
            spawn_valid_q <= spawn_valid_d;
            cta_done_q    <= cta_done_d;
            grid_done_q   <= grid_done_d;
            cfg_err_q     <= cfg_err_d;
`ifdef VX_CTA_DISPATCH_PERF_EN
            if (cta_done_q) begin
                perf_ctas_q <= perf_ctas_q + 32'd1;
            end
            if (state_q != S_IDLE) begin
                perf_busy_q <= perf_busy_q + 64'd1;
            end
`endif
        end
    end

    assign core_ready  = core_ready_q;
    assign spawn_valid = spawn_valid_q;
    assign spawn_wid   = spawn_cnt_q[WW-1:0];
    assign spawn_pc    = pc_q;
    assign spawn_tmask = {NUM_THREADS{spawn_valid_q}};
    assign cur_cta_id  = cta_id_q;
    assign cur_cta_x   = cta_x_q;
    assign cur_cta_y   = cta_y_q;
    assign cur_cta_z   = cta_z_q;
    assign cur_param   = param_q;
    assign cta_done    = cta_done_q;
    assign grid_done   = grid_done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vx_cta_dispatch.sv
// tb/tb_vx_cta_dispatch.sv - directed and randomized checks of vx_cta_dispatch against a warp-set model
module tb_vx_cta_dispatch;
    localparam int NW = 4;
    localparam int NT = 4;
    localparam int XL = 32;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          task_valid;
    logic [XL-1:0] task_start_pc, task_param, task_cta_x, task_cta_y, task_cta_z;
    logic [31:0]   task_cta_id, task_num_warps;
    logic          core_ready, spawn_valid, spawn_ready;
    logic [WW-1:0] spawn_wid;
    logic [XL-1:0] spawn_pc;
    logic [NT-1:0] spawn_tmask;
    logic          warp_done_valid;
    logic [WW-1:0] warp_done_wid;
    logic [31:0]   cur_cta_id;
    logic [XL-1:0] cur_cta_x, cur_cta_y, cur_cta_z, cur_param;
    logic          cta_done, grid_done, cfg_err;
`ifdef VX_CTA_DISPATCH_PERF_EN
    logic [31:0]   perf_ctas;
    logic [63:0]   perf_busy_cycles;
`endif

    vx_cta_dispatch #(.NUM_WARPS(NW), .NUM_THREADS(NT), .XLEN(XL)) dut (
        .clk(clk), .reset(reset), .task_valid(task_valid),
        .task_start_pc(task_start_pc), .task_param(task_param),
        .task_cta_x(task_cta_x), .task_cta_y(task_cta_y), .task_cta_z(task_cta_z),
        .task_cta_id(task_cta_id), .task_num_warps(task_num_warps),
        .core_ready(core_ready), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_wid(spawn_wid), .spawn_pc(spawn_pc), .spawn_tmask(spawn_tmask),
        .warp_done_valid(warp_done_valid), .warp_done_wid(warp_done_wid),
        .cur_cta_id(cur_cta_id), .cur_cta_x(cur_cta_x), .cur_cta_y(cur_cta_y),
        .cur_cta_z(cur_cta_z), .cur_param(cur_param),
        .cta_done(cta_done), .grid_done(grid_done), .cfg_err(cfg_err)
`ifdef VX_CTA_DISPATCH_PERF_EN
        , .perf_ctas(perf_ctas), .perf_busy_cycles(perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    bit exp_cfg = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cta_done) done_cnt++;
        if (!core_ready && !grid_done) busy_cnt++;
    endtask

    function automatic int exp_warps(input int unsigned n);
        if (n == 0) return 1;
        if (n > NW) return NW;
        return int'(n);
    endfunction

    task automatic present(input logic [31:0] n, input logic [XL-1:0] pc, input logic [XL-1:0] x);
        task_valid     = 1'b1;
        task_num_warps = n;
        task_start_pc  = pc;
        task_cta_x     = x;
        task_cta_y     = $urandom;
        task_cta_z     = $urandom;
        task_cta_id    = $urandom;
        task_param     = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_cfg = 1'b0;
    endtask

    // One CTA with random ready/retire traffic; model tracks the live warp set
    task automatic run_random(input int unsigned n, input bit stall);
        int k;
        int d0;
        int budget;
        int live_n;
        bit live[NW];
        int got_wid[$];
        logic [XL-1:0] got_pc[$];
        logic [XL-1:0] pc;
        logic [XL-1:0] xv;
        logic [XL-1:0] pv;
        bit hs;
        int hw;
        int dw;
        k = exp_warps(n);
        pc = $urandom & 32'hFFFF_FFFC;
        xv = $urandom_range(0, 5000);
        d0 = done_cnt;
        for (int i = 0; i < NW; i++) live[i] = 1'b0;
        present(n, pc, xv);
        pv = task_param;
        if (n > NW) exp_cfg = 1'b1;
        spawn_ready = stall ? 1'b0 : 1'(($urandom_range(0, 1)));
        tick();
        task_valid = 1'b0;
        check("rnd_ready_low", core_ready, 0);
        check("rnd_first_valid", spawn_valid, 1);
        check("rnd_first_wid", spawn_wid, 0);
        check("rnd_tmask", spawn_tmask, 4'hF);
        check("rnd_cur_x", cur_cta_x, xv);
        check("rnd_cur_param", cur_param, pv);
        check("rnd_cfg_err", cfg_err, exp_cfg);
        if (stall) begin
            for (int c = 0; c < 5; c++) begin
                check("stall_valid", spawn_valid, 1);
                check("stall_wid", spawn_wid, 0);
                check("stall_pc", spawn_pc, pc);
                tick();
            end
        end
        budget = 0;
        while (done_cnt == d0 && budget < 300) begin
            spawn_ready = 1'(($urandom_range(0, 1)));
            warp_done_valid = 1'b0;
            dw = -1;
            live_n = 0;
            for (int i = 0; i < NW; i++) if (live[i]) live_n++;
            if (live_n > 0 && $urandom_range(0, 1) == 1) begin
                do dw = $urandom_range(0, NW - 1); while (!live[dw]);
                warp_done_valid = 1'b1;
                warp_done_wid   = WW'(dw);
            end else if ($urandom_range(0, 5) == 0) begin
                warp_done_valid = 1'b1;
                warp_done_wid   = WW'($urandom_range(0, NW - 1));
                if (live[warp_done_wid]) dw = int'(warp_done_wid);
            end
            hs = spawn_valid && spawn_ready;
            hw = int'(spawn_wid);
            if (hs) begin
                got_wid.push_back(hw);
                got_pc.push_back(spawn_pc);
            end
            tick();
            if (dw >= 0) live[dw] = 1'b0;
            if (hs) live[hw] = 1'b1;
            budget++;
        end
        warp_done_valid = 1'b0;
        live_n = 0;
        for (int i = 0; i < NW; i++) if (live[i]) live_n++;
        check("rnd_done_pulses", done_cnt - d0, 1);
        check("rnd_live_at_done", live_n, 0);
        check("rnd_spawn_count", got_wid.size(), k);
        foreach (got_wid[i]) begin
            check("rnd_spawn_wid", got_wid[i], i);
            check("rnd_spawn_pc", got_pc[i], pc);
        end
        tick();
        check("rnd_done_one_cycle", cta_done, 0);
        check("rnd_ready_back", core_ready, 1);
    endtask

    initial begin
        int d0;
        logic [XL-1:0] pc;
        task_valid = 1'b0; task_start_pc = '0; task_param = '0;
        task_cta_x = '0; task_cta_y = '0; task_cta_z = '0;
        task_cta_id = '0; task_num_warps = '0;
        spawn_ready = 1'b0; warp_done_valid = 1'b0; warp_done_wid = '0;
        do_reset();
        check("rst_core_ready", core_ready, 1);
        check("rst_spawn_valid", spawn_valid, 0);
        check("rst_tmask", spawn_tmask, 0);
        check("rst_cta_done", cta_done, 0);
        check("rst_grid_done", grid_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cur_id", cur_cta_id, 0);

        // Directed: 3 warps back to back, retire order 2,0,1
        pc = 32'h8000_0000;
        present(3, pc, 32'd7);
        spawn_ready = 1'b1;
        d0 = done_cnt;
        tick();
        task_valid = 1'b0;
        check("d_ready_fall", core_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check("d_spawn_valid", spawn_valid, 1);
            check("d_spawn_wid", spawn_wid, i);
            check("d_spawn_pc", spawn_pc, pc);
            tick();
        end
        check("d_spawn_end", spawn_valid, 0);
        warp_done_valid = 1'b1;
        warp_done_wid = 2'd2; tick();
        warp_done_wid = 2'd0; tick();
        warp_done_wid = 2'd1; tick();
        warp_done_valid = 1'b0;
        for (int c = 0; c < 20 && !core_ready; c++) tick();
        check("d_done_pulse", done_cnt - d0, 1);
        check("d_ready_back", core_ready, 1);

        run_random(2, 1'b1);
        run_random(0, 1'b0);
        run_random(9, 1'b0);
        for (int r = 0; r < 8; r++) run_random($urandom_range(0, 9), 1'b0);

        // Done for a non-live wid is ignored; reset in RUN clears everything
        present(1, 32'h100, 32'd1);
        spawn_ready = 1'b1;
        d0 = done_cnt;
        tick();
        task_valid = 1'b0;
        tick();
        check("ign_spawn_end", spawn_valid, 0);
        warp_done_valid = 1'b1;
        warp_done_wid = 2'd3;
        tick();
        warp_done_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("ign_no_done", done_cnt - d0, 0);
        check("ign_busy", core_ready, 0);
        check("ign_cfg_sticky", cfg_err, 1);
        reset = 1'b1;
        tick();
        check("rrun_core_ready", core_ready, 1);
        check("rrun_cfg_err", cfg_err, 0);
        check("rrun_cur_id", cur_cta_id, 0);
        check("rrun_cur_param", cur_param, 0);
        check("rrun_spawn_pc", spawn_pc, 0);
        reset = 1'b0;
        exp_cfg = 1'b0;
        tick();
        check("rrun_idle", core_ready, 1);

`ifdef VX_CTA_DISPATCH_PERF_EN
        do_reset();
        busy_cnt = 0;
        run_random(1, 1'b0);
        run_random(1, 1'b0);
        check("perf_ctas", perf_ctas, 2);
        check("perf_busy", perf_busy_cycles, busy_cnt);
`endif

        // Grid terminator: sticky, blocks further descriptors until reset
        present(5, 32'h200, 32'hFFFF_FFFF);
        tick();
        check("grid_done_set", grid_done, 1);
        check("grid_ready_low", core_ready, 0);
        check("grid_no_spawn", spawn_valid, 0);
        present(2, 32'h300, 32'd3);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("grid_blocked_spawn", spawn_valid, 0);
            check("grid_blocked_ready", core_ready, 0);
        end
        task_valid = 1'b0;
        do_reset();
        check("grid_cleared", grid_done, 0);
        check("grid_ready_back", core_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vx_cta_dispatch.md
Name: VX_cta_dispatch

Overview:
- Per-core consumer of the kernel management unit's task interface.
- Accepts one CTA descriptor (start PC, param, CTA coordinates/id, warp count) while idle, spawns its warps one per handshake into the core's warp scheduler, and tracks warp completion.
- Reasserts core_ready once every warp of the CTA has retired.
- Sits between the KMU task distributor and the core's warp-spawn/retire path.

Parameters:
- NUM_WARPS, 4, warps per core; width of the live mask and warp-id range.
- NUM_THREADS, 4, threads per warp; width of spawn_tmask.
- XLEN, 32, width of the PC, param and CTA coordinate fields.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- task_valid  input  1  KMU presents a descriptor.
- task_start_pc  input  XLEN  kernel entry PC.
- task_param  input  XLEN  kernel argument pointer.
- task_cta_x / task_cta_y / task_cta_z  input  XLEN each  CTA coordinates; cta_x all-ones = grid exhausted.
- task_cta_id  input  32  linear CTA id.
- task_num_warps  input  32  warps required by the CTA.
- core_ready  output  1  block can accept a descriptor.
- spawn_valid  output  1  warp spawn request.
- spawn_ready  input  1  scheduler accepts spawn.
- spawn_wid  output  log2(NUM_WARPS)  warp id being spawned.
- spawn_pc  output  XLEN  latched start_pc.
- spawn_tmask  output  NUM_THREADS  all ones.
- warp_done_valid  input  1  a warp retired.
- warp_done_wid  input  log2(NUM_WARPS)  id of the retired warp.
- cur_cta_id / cur_cta_x / cur_cta_y / cur_cta_z / cur_param  output  32/XLEN  latched descriptor, for CSR reads.
- cta_done  output  1  one-cycle pulse when the CTA completes.
- grid_done  output  1  sticky; set once the terminator descriptor is seen.
- cfg_err  output  1  sticky; set when task_num_warps > NUM_WARPS.

Behaviour:
- Reset values: FSM state IDLE; all outputs 0 except core_ready, which is 1 from the first cycle after reset deasserts.
- Reset mid-operation drops the CTA, live mask, counters and sticky flags.
- FSM states: IDLE, SPAWN, RUN, DONE.
- IDLE:
  - core_ready = 1 and not grid_done.
  - Accept on task_valid && core_ready: latch the descriptor, set spawn_cnt = 0.
  - Latched warp count: task_num_warps == 0 is treated as 1; a value > NUM_WARPS is clamped to NUM_WARPS and sets cfg_err.
  - Next state SPAWN.
  - If task_cta_x == all-ones: set grid_done, latch nothing, remain IDLE.
- SPAWN:
  - spawn_valid = 1; spawn_wid = spawn_cnt; spawn_pc = latched PC.
  - On spawn_valid && spawn_ready: set live[spawn_cnt] and increment spawn_cnt.
  - spawn_valid, wid and pc stay stable until the handshake.
  - When the last warp handshakes, go to RUN in the next cycle.
  - Latency: first spawn_valid in the cycle after accept; at most one spawn per cycle.
- Retire (applies in SPAWN and RUN): warp_done_valid clears live[warp_done_wid].
  - A done for a wid not in live is ignored.
  - A done and a spawn in the same cycle are both applied, including on the same wid (done clears, spawn sets → set).
- RUN: when live == 0, go to DONE.
- DONE: cta_done = 1 for exactly one cycle, then IDLE. core_ready returns to 1 in the IDLE cycle.
- core_ready is a registered output: no combinational path from task_valid.
- Descriptor outputs hold their last value until the next accept.

Optional Feature:
VX_CTA_DISPATCH_PERF_EN:
- When defined, adds output ports perf_ctas (32 bits) and perf_busy_cycles (64 bits).
  - perf_ctas increments on each cta_done pulse.
  - perf_busy_cycles increments every cycle the state is not IDLE.
  - Both clear on reset and wrap at their maximum value.
- When undefined, these ports and counters do not exist.

Test Plan:
- Reset, then task_valid with num_warps = 3, pc = 0x8000_0000, spawn_ready = 1:
  - core_ready falls the cycle after accept.
  - Wids 0, 1, 2 spawn on three consecutive cycles, all with pc 0x8000_0000.
  - Done for 2, 0, 1 → cta_done pulses once, then core_ready = 1.
- spawn_ready held 0 for 5 cycles during SPAWN → spawn_wid and spawn_pc stay stable with spawn_valid high; no spawn_cnt advance.
- num_warps = 0 → exactly one warp (wid 0) spawned. num_warps = 9 with NUM_WARPS = 4 → 4 warps spawned and cfg_err = 1.
- Descriptor with cta_x = 0xFFFF_FFFF → grid_done = 1, no spawn, core_ready = 0 thereafter until reset.
- warp_done for wid 3 while only wid 0 is live → ignored, CTA stays in RUN. Reset asserted in RUN → all outputs return to reset values.
- With VX_CTA_DISPATCH_PERF_EN, two back-to-back 1-warp CTAs → perf_ctas = 2; perf_busy_cycles equals the measured non-IDLE cycles.
